// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, parity modes, frame length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Bit periods in one frame: start + data + optional parity + stop bits.
    function automatic int unsigned frame_bits(input int unsigned dbit,
                                               input int unsigned par_en,
                                               input int unsigned stop_bits);
        return 1 + dbit + ((par_en != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Line front end: 2-flop synchroniser, oversample tick counter and 3-sample majority voter.
// dec_o strobes for one clk on the tick where the voted bit for the current bit period is final.
module uart_rx_sync #(
    parameter int unsigned OS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    input  logic s_tick_i,
    input  logic clr_i,
    output logic rx_sync_o,
    output logic vote_o,
    output logic dec_o
);

    localparam int unsigned CW = $clog2(OS);
    localparam logic [CW-1:0] T_A  = CW'(OS / 2 - 1);
    localparam logic [CW-1:0] T_B  = CW'(OS / 2);
    localparam logic [CW-1:0] T_C  = CW'(OS / 2 + 1);
    localparam logic [CW-1:0] LAST = CW'(OS - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    smp_q, smp_d;

    assign rx_sync_o = sync_q[1];

    // Two-stage synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    // Tick counter and capture of the first two vote samples.
    always_comb begin
        cnt_d = cnt_q;
        smp_d = smp_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (s_tick_i) begin
            if (cnt_q == T_A) smp_d[0] = rx_sync_o;
            if (cnt_q == T_B) smp_d[1] = rx_sync_o;
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter and sample registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            smp_q <= '1;
        end else begin
            cnt_q <= cnt_d;
            smp_q <= smp_d;
        end
    end

    // Third sample is the live synced level on the decision tick.
    always_comb begin
        dec_o  = s_tick_i && !clr_i && (cnt_q == T_C);
        vote_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_o) | (smp_q[1] & rx_sync_o);
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receiver: framing FSM, shift register, parity/stop/break checks and a
// single-entry valid/ready holding register with overrun reporting.
module uart_rx_ctrl import uart_pkg::*; #(
    parameter int unsigned DBIT      = 8,
    parameter int unsigned OS        = 16,
    parameter int unsigned PARITY_EN = 1,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    input  logic            s_tick,
    input  logic            parity_odd,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            parity_err,
    output logic            frame_err,
    output logic            break_det,
    output logic            overrun_err
);

    localparam int unsigned BCW = $clog2(DBIT + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DBIT - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    rx_state_e       state_q, state_d;
    logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic            par_odd_q, par_odd_d;
    logic            par_bit_q, par_bit_d;
    logic            stop0_q, stop0_d;
    logic            run_fe_q, run_fe_d;

    logic [DBIT-1:0] dout_q, dout_d;
    logic            valid_q, valid_d;
    logic            pe_q, pe_d;
    logic            fe_q, fe_d;
    logic            bk_q, bk_d;
    logic            ovr_q, ovr_d;

    logic            rx_sync, vote, dec, clr;
    logic            done, done_pe, done_fe, done_bk, first_stop;

    assign clr = (state_q == ST_IDLE) || (state_q == ST_BRK_WAIT);

    uart_rx_sync #(.OS(OS)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (rx),
        .s_tick_i  (s_tick),
        .clr_i     (clr),
        .rx_sync_o (rx_sync),
        .vote_o    (vote),
        .dec_o     (dec)
    );

    // Frame FSM: advances on bit decisions, reports completion with its flags.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_odd_d  = par_odd_q;
        par_bit_d  = par_bit_q;
        stop0_d    = stop0_q;
        run_fe_d   = run_fe_q;
        done       = 1'b0;
        done_pe    = 1'b0;
        done_fe    = 1'b0;
        done_bk    = 1'b0;
        first_stop = stop0_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_sync) state_d = ST_START;
            end
            ST_START: begin
                if (dec) begin
                    if (vote) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        par_odd_d = parity_odd;
                        par_bit_d = 1'b0;
                        run_fe_d  = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (dec) begin
                    shreg_d = {vote, shreg_q[DBIT-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (dec) begin
                    par_bit_d = vote;
                    bit_cnt_d = '0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (dec) begin
                    first_stop = (bit_cnt_q == '0) ? vote : stop0_q;
                    stop0_d    = first_stop;
                    run_fe_d   = run_fe_q | ~vote;
                    if (bit_cnt_q == LAST_STOP) begin
                        done    = 1'b1;
                        done_fe = run_fe_q | ~vote;
                        done_pe = (PARITY_EN != 0) ? ((^shreg_q ^ par_bit_q) != par_odd_q) : 1'b0;
                        done_bk = (shreg_q == '0) && !par_bit_q && !first_stop;
                        state_d = done_bk ? ST_BRK_WAIT : ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_BRK_WAIT: begin
                if (rx_sync) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_odd_q <= 1'b0;
            par_bit_q <= 1'b0;
            stop0_q   <= 1'b0;
            run_fe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_odd_q <= par_odd_d;
            par_bit_q <= par_bit_d;
            stop0_q   <= stop0_d;
            run_fe_q  <= run_fe_d;
        end
    end

    // Holding register: load on completion if free or being popped, otherwise drop and flag overrun.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        bk_d    = bk_q;
        ovr_d   = 1'b0;
        if (done) begin
            if (!valid_q || rx_ready) begin
                dout_d  = shreg_q;
                valid_d = 1'b1;
                pe_d    = done_pe;
                fe_d    = done_fe;
                bk_d    = done_bk;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
            pe_d    = 1'b0;
            fe_d    = 1'b0;
            bk_d    = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            bk_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            bk_q    <= bk_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_dout     = dout_q;
    assign rx_valid    = valid_q;
    assign parity_err  = pe_q;
    assign frame_err   = fe_q;
    assign break_det   = bk_q;
    assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl (DBIT=8, OS=16, parity on, one stop bit).
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int unsigned DBIT = 8;
    localparam int unsigned OS   = 16;
    localparam int unsigned TDIV = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       s_tick = 1'b0;
    logic       parity_odd = PAR_EVEN;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_dout;
    logic       rx_valid, parity_err, frame_err, break_det, overrun_err;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned valid_cyc = 0;
    int unsigned ovr_cnt = 0;
    int unsigned div = 0;
    rec_t got_q[$];
    rec_t exp_q[$];

    uart_rx_ctrl #(.DBIT(DBIT), .OS(OS), .PARITY_EN(1), .STOP_BITS(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .s_tick      (s_tick),
        .parity_odd  (parity_odd),
        .rx_dout     (rx_dout),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .break_det   (break_det),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div    <= (div == TDIV - 1) ? 0 : div + 1;
        s_tick <= (div == TDIV - 1);
    end

    // Record every accepted word and count valid/overrun cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) got_q.push_back({rx_dout, parity_err, frame_err, break_det});
            if (rx_valid) valid_cyc <= valid_cyc + 1;
            if (overrun_err) ovr_cnt <= ovr_cnt + 1;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Expected word/flags from the framing rules.
    function automatic rec_t model(input logic [7:0] d, input logic pb, input logic s0, input logic odd);
        rec_t r;
        r.d  = d;
        r.pe = ((($countones(d) + int'(pb)) % 2) == 1) != odd;
        r.fe = !s0;
        r.bk = (d == 8'h00) && !pb && !s0;
        return r;
    endfunction

    task automatic wait_tick();
        do @(posedge clk); while (s_tick !== 1'b1);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        rx = 1'b1;
        repeat (n) wait_tick();
    endtask

    task automatic drive_bit(input logic v, input int gt);
        for (int t = 0; t < int'(OS); t++) begin
            rx = (t == gt) ? ~v : v;
            wait_tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic s0,
                              input int gbit, input int gt, input int unsigned gap);
        drive_bit(1'b0, (gbit == 0) ? gt : -1);
        for (int i = 0; i < 8; i++) drive_bit(d[i], (gbit == i + 1) ? gt : -1);
        drive_bit(pb, (gbit == 9) ? gt : -1);
        drive_bit(s0, -1);
        idle(gap);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({rx_valid, parity_err, frame_err, break_det, overrun_err} !== 5'b0) begin
            $display("FAIL reset_flags got %b required 00000",
                     {rx_valid, parity_err, frame_err, break_det, overrun_err});
            miscompares++;
        end
        vectors++;
        if (rx_dout !== 8'h00) begin
            $display("FAIL reset_dout got %h required 00", rx_dout);
            miscompares++;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        idle(4);
    endtask

    task automatic test_basic();
        rec_t g, e;
        int unsigned v0;
        parity_odd = PAR_EVEN;
        rx_ready   = 1'b1;
        v0 = valid_cyc;
        send_frame(8'hA5, ^8'hA5, 1'b1, -1, -1, OS);
        exp_q.push_back(model(8'hA5, ^8'hA5, 1'b1, PAR_EVEN));
        vectors++;
        if (valid_cyc - v0 != 1) begin
            $display("FAIL basic_valid_width got %0d required 1", valid_cyc - v0);
            miscompares++;
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL basic_count got %0d required %0d", got_q.size(), exp_q.size());
            miscompares++;
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                $display("FAIL basic_word got d=%h pe=%b fe=%b bk=%b required d=%h pe=%b fe=%b bk=%b",
                         g.d, g.pe, g.fe, g.bk, e.d, e.pe, e.fe, e.bk);
                miscompares++;
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_parity();
        rec_t g, e;
        parity_odd = PAR_ODD;
        send_frame(8'h3C, 1'b0, 1'b1, -1, -1, 2);
        exp_q.push_back(model(8'h3C, 1'b0, 1'b1, PAR_ODD));
        send_frame(8'h3C, 1'b1, 1'b1, -1, -1, 2);
        exp_q.push_back(model(8'h3C, 1'b1, 1'b1, PAR_ODD));
        parity_odd = PAR_EVEN;
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL parity_count got %0d required %0d", got_q.size(), exp_q.size());
            miscompares++;
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                $display("FAIL parity_word got d=%h pe=%b fe=%b bk=%b required d=%h pe=%b fe=%b bk=%b",
                         g.d, g.pe, g.fe, g.bk, e.d, e.pe, e.fe, e.bk);
                miscompares++;
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_false_start();
        rec_t g, e;
        int unsigned v0;
        v0 = valid_cyc;
        rx = 1'b0;
        repeat (4) wait_tick();
        idle(2 * OS);
        vectors++;
        if (got_q.size() != 0 || valid_cyc != v0) begin
            $display("FAIL false_start_quiet got words=%0d valid_cycles=%0d required 0 0",
                     got_q.size(), valid_cyc - v0);
            miscompares++;
        end
        got_q.delete();
        send_frame(8'h5A, ^8'h5A, 1'b1, -1, -1, 4);
        exp_q.push_back(model(8'h5A, ^8'h5A, 1'b1, PAR_EVEN));
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL false_start_count got %0d required %0d", got_q.size(), exp_q.size());
            miscompares++;
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                $display("FAIL false_start_word got d=%h pe=%b fe=%b bk=%b required d=%h pe=%b fe=%b bk=%b",
                         g.d, g.pe, g.fe, g.bk, e.d, e.pe, e.fe, e.bk);
                miscompares++;
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_overrun();
        rec_t e;
        int unsigned o0;
        o0 = ovr_cnt;
        rx_ready = 1'b0;
        e = model(8'h11, ^8'h11, 1'b1, PAR_EVEN);
        send_frame(8'h11, ^8'h11, 1'b1, -1, -1, 2);
        send_frame(8'h22, ^8'h22, 1'b1, -1, -1, 4);
        @(negedge clk);
        vectors++;
        if (rx_valid !== 1'b1) begin
            $display("FAIL overrun_held_valid got %b required 1", rx_valid);
            miscompares++;
        end
        vectors++;
        if ({rx_dout, parity_err, frame_err, break_det} !== e) begin
            $display("FAIL overrun_held_word got d=%h pe=%b fe=%b bk=%b required d=%h pe=%b fe=%b bk=%b",
                     rx_dout, parity_err, frame_err, break_det, e.d, e.pe, e.fe, e.bk);
            miscompares++;
        end
        vectors++;
        if (ovr_cnt - o0 != 1) begin
            $display("FAIL overrun_pulses got %0d required 1", ovr_cnt - o0);
            miscompares++;
        end
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (rx_valid !== 1'b0) begin
            $display("FAIL overrun_pop_valid got %b required 0", rx_valid);
            miscompares++;
        end
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== e) begin
            $display("FAIL overrun_pop_word got count=%0d required count=1 d=%h", got_q.size(), e.d);
            miscompares++;
        end
        got_q.delete();
        rx_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_break();
        rec_t e;
        parity_odd = PAR_EVEN;
        e = model(8'h00, 1'b0, 1'b0, PAR_EVEN);
        rx = 1'b0;
        repeat (20 * OS) wait_tick();
        idle(2 * OS);
        vectors++;
        if (got_q.size() != 1) begin
            $display("FAIL break_count got %0d required 1", got_q.size());
            miscompares++;
        end
        vectors++;
        if (got_q.size() > 0 && got_q[0] !== e) begin
            $display("FAIL break_word got d=%h pe=%b fe=%b bk=%b required d=%h pe=%b fe=%b bk=%b",
                     got_q[0].d, got_q[0].pe, got_q[0].fe, got_q[0].bk, e.d, e.pe, e.fe, e.bk);
            miscompares++;
        end
        got_q.delete();
    endtask

    task automatic test_glitch();
        rec_t e;
        e = model(8'hFF, ^8'hFF, 1'b1, PAR_EVEN);
        send_frame(8'hFF, ^8'hFF, 1'b1, 4, 7, 4);
        vectors++;
        if (got_q.size() != 1) begin
            $display("FAIL glitch_count got %0d required 1", got_q.size());
            miscompares++;
        end
        vectors++;
        if (got_q.size() > 0 && got_q[0] !== e) begin
            $display("FAIL glitch_word got d=%h pe=%b fe=%b bk=%b required d=%h pe=%b fe=%b bk=%b",
                     got_q[0].d, got_q[0].pe, got_q[0].fe, got_q[0].bk, e.d, e.pe, e.fe, e.bk);
            miscompares++;
        end
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        rec_t e;
        logic [7:0] d;
        d = 8'h81;
        drive_bit(1'b0, -1);
        for (int i = 0; i < 3; i++) drive_bit(d[i], -1);
        rx = d[3];
        repeat (OS / 2) wait_tick();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({rx_valid, parity_err, frame_err, break_det, overrun_err} !== 5'b0 || rx_dout !== 8'h00) begin
            $display("FAIL reset_mid_outputs got valid=%b dout=%h flags=%b required 0 00 0000",
                     rx_valid, rx_dout, {parity_err, frame_err, break_det, overrun_err});
            miscompares++;
        end
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(frame_bits(DBIT, 1, 1) * OS);
        vectors++;
        if (got_q.size() != 0) begin
            $display("FAIL reset_mid_quiet got %0d words required 0", got_q.size());
            miscompares++;
        end
        got_q.delete();
        e = model(8'h42, ^8'h42, 1'b1, PAR_EVEN);
        send_frame(8'h42, ^8'h42, 1'b1, -1, -1, 4);
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== e) begin
            $display("FAIL reset_mid_next got count=%0d required count=1 d=%h", got_q.size(), e.d);
            miscompares++;
        end
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        rec_t g, e;
        logic [7:0] d;
        logic pb, s0, odd;
        for (int n = 0; n < 16; n++) begin
            d   = 8'($urandom);
            odd = 1'($urandom);
            pb  = (^d) ^ odd ^ ($urandom_range(0, 3) == 0);
            s0  = ($urandom_range(0, 4) != 0);
            parity_odd = odd;
            exp_q.push_back(model(d, pb, s0, odd));
            send_frame(d, pb, s0, -1, -1, s0 ? $urandom_range(0, 3) : OS + $urandom_range(0, 3));
        end
        parity_odd = PAR_EVEN;
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            $display("FAIL b2b_count got %0d required %0d", got_q.size(), exp_q.size());
            miscompares++;
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            vectors++;
            if (g !== e) begin
                $display("FAIL b2b_word got d=%h pe=%b fe=%b bk=%b required d=%h pe=%b fe=%b bk=%b",
                         g.d, g.pe, g.fe, g.bk, e.d, e.pe, e.fe, e.bk);
                miscompares++;
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_false_start();
        test_overrun();
        test_break();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
